inst_fetch_queue: RTL and testbench

//  Front-end stage directly upstream of the instruction decoder. Holds the fetch PC and issues one
//  32-bit instruction read at a time to the memory controller. Statically predicts JAL targets and

---
 rtl/inst_fetch_queue_pkg.sv | 29 ++
 rtl/inst_fetch_queue_fetch_fifo.sv | 57 +++++
 rtl/inst_fetch_queue.sv | 118 +++++++++++
 tb/tb_inst_fetch_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch/decode definitions: opcode constants, queue entry layout, FSM states and the
// static next-PC predictor.
package inst_fetch_queue_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [6:0]  OPC_JAL    = 7'h6f;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [31:0]           pc;
    logic [31:0]           pred_pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

  // JAL is predicted taken; branches and JALR fall through.
  function automatic logic [31:0] predict_npc(input logic [31:0]           pc,
                                              input logic [DATA_WIDTH-1:0] inst);
    if (inst[6:0] == OPC_JAL) begin
      return pc + {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    end
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Circular buffer of fetched {inst, pc, pred_pc} entries; head entry is read straight from
// storage so an entry written at one edge is visible right after it.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         enq_i,
  input  logic         deq_i,
  input  logic         clear_i,
  input  fetch_entry_t enq_data_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_i) begin
        mem_q[tail_q] <= enq_data_i;
        tail_q        <= tail_q + PtrW'(1);
      end
      if (deq_i) begin
        head_q <= head_q + PtrW'(1);
      end
      unique case ({enq_i, deq_i})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: one outstanding instruction read, static JAL prediction, in-order queue to
// decode, full flush on redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  mem_req_valid,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [31:0]           inst_pc_out,
  output logic [31:0]           inst_pred_pc_out,
  input  logic                  inst_deq,
  input  logic                  flush_in,
  input  logic [31:0]           flush_pc_in
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         req_valid_q, req_valid_d;
  logic         enq, fifo_enq, fifo_deq, fifo_clear;
  logic         fifo_full, fifo_empty;
  logic [31:0]  npc;
  fetch_entry_t enq_entry, head;

  assign npc       = predict_npc(pc_q, mem_resp_data);
  assign enq_entry = '{inst: mem_resp_data, pc: pc_q, pred_pc: npc};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    enq         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_in) begin
          pc_d = flush_pc_in;
        end else if (!fifo_full) begin
          req_valid_d = 1'b1;
          req_addr_d  = pc_q;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (flush_in) begin
          // A response in the flush cycle is stale; otherwise it is still to come.
          pc_d        = flush_pc_in;
          req_valid_d = 1'b0;
          state_d     = mem_resp_valid ? StIdle : StDrop;
        end else if (mem_resp_valid) begin
          enq         = 1'b1;
          pc_d        = npc;
          req_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StDrop: begin
        if (flush_in) begin
          pc_d = flush_pc_in;
        end
        if (mem_resp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  // Flush wins over enqueue and dequeue; rdy_in low freezes the queue as well.
  assign fifo_clear = rdy_in & flush_in;
  assign fifo_enq   = rdy_in & enq;
  assign fifo_deq   = rdy_in & inst_deq & ~fifo_empty & ~flush_in;

  fetch_fifo #(
    .Depth(QUEUE_DEPTH)
  ) u_fetch_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .enq_i     (fifo_enq),
    .deq_i     (fifo_deq),
    .clear_i   (fifo_clear),
    .enq_data_i(enq_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

  assign mem_req_valid    = req_valid_q;
  assign mem_req_addr     = req_addr_q;
  assign inst_valid       = ~fifo_empty;
  assign inst_out         = head.inst;
  assign inst_pc_out      = head.pc;
  assign inst_pred_pc_out = head.pred_pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: expected requests/entries are queued by the stimulus,
// a monitor pops and compares them as the DUT presents requests and dequeued heads.
module tb_inst_fetch_queue;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, inst_deq, flush_in;
  logic [31:0] flush_pc_in;
  logic        mem_req_valid, mem_resp_valid, inst_valid;
  logic [31:0] mem_req_addr, mem_resp_data, inst_out, inst_pc_out, inst_pred_pc_out;

  logic        auto_en = 1'b0, auto_v = 1'b0, man_v = 1'b0, jal_neg = 1'b0;
  logic [31:0] auto_d = '0, man_d = '0;
  logic        prev_req = 1'b0;
  int          n_checks = 0, n_errors = 0, req_seen = 0;
  ent_t        exp_ent[$];
  logic [31:0] exp_req[$];
  ent_t        mon_e;

  always #5 clk = ~clk;

  assign mem_resp_valid = auto_v | man_v;
  assign mem_resp_data  = man_v ? man_d : auto_d;

  inst_fetch_queue #(
    .QUEUE_DEPTH(16),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .inst_valid      (inst_valid),
    .inst_out        (inst_out),
    .inst_pc_out     (inst_pc_out),
    .inst_pred_pc_out(inst_pred_pc_out),
    .inst_deq        (inst_deq),
    .flush_in        (flush_in),
    .flush_pc_in     (flush_pc_in)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0100006f;          // JAL +16
    if (a == 32'h0 && jal_neg) return 32'hffdff06f; // JAL -4
    return 32'h00000013;
  endfunction

  // Memory model: answers one cycle after it sees a request, never while frozen.
  always @(negedge clk) begin
    #1;
    if (auto_en && rst_in && rdy_in && mem_req_valid && !auto_v) begin
      auto_v = 1'b1;
      auto_d = mem_word(mem_req_addr);
    end else begin
      auto_v = 1'b0;
    end
  end

  // Monitor: new request -> compare address; head taken by consumer -> compare entry.
  always @(negedge clk) begin
    #2;
    if (!rst_in) begin
      prev_req = 1'b0;
    end else if (rdy_in) begin
      if (mem_req_valid && !prev_req) begin
        req_seen++;
        if (exp_req.size() > 0) check("req_addr", 128'(mem_req_addr), 128'(exp_req.pop_front()));
      end
      if (inst_valid && inst_deq && !flush_in && exp_ent.size() > 0) begin
        mon_e = exp_ent.pop_front();
        check("head_entry", 128'({inst_out, inst_pc_out, inst_pred_pc_out}), 128'(mon_e));
      end
      prev_req = mem_req_valid;
    end
  end

  task automatic push_nop(input logic [31:0] pc);
    exp_ent.push_back({32'h13, pc, pc + 32'd4});
  endtask

  task automatic reset_low();
    @(negedge clk);
    rst_in = 1'b0; inst_deq = 1'b0; flush_in = 1'b0; man_v = 1'b0; rdy_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int i = 0;
    while (!mem_req_valid && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!mem_req_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: mem_req_valid stayed 0, required 1", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while ((exp_req.size() != 0 || exp_ent.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (exp_req.size() != 0 || exp_ent.size() != 0) begin
      n_errors++;
      $display("FAIL %s drain: %0d requests and %0d entries outstanding, required 0 and 0",
               name, exp_req.size(), exp_ent.size());
    end
    exp_req.delete();
    exp_ent.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_in = 1'b0; rdy_in = 1'b1; inst_deq = 1'b0; flush_in = 1'b0; flush_pc_in = '0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 128'(mem_req_valid), 128'(0));
    check("rst_req_addr", 128'(mem_req_addr), 128'(0));
    check("rst_inst_valid", 128'(inst_valid), 128'(0));
    check("rst_head", 128'({inst_out, inst_pc_out, inst_pred_pc_out}), 128'(0));

    // Sequential NOP stream.
    for (int a = 0; a < 12; a += 4) begin
      exp_req.push_back(32'(a));
      push_nop(32'(a));
    end
    auto_en = 1'b1; inst_deq = 1'b1; rst_in = 1'b1;
    wait_drain("seq");

    // JAL +16 at 0x100, reached through a flush taken in IDLE.
    reset_low();
    exp_req.push_back(32'h100); exp_req.push_back(32'h110); exp_req.push_back(32'h114);
    exp_ent.push_back({32'h0100006f, 32'h100, 32'h110});
    push_nop(32'h110);
    flush_in = 1'b1; flush_pc_in = 32'h100; rst_in = 1'b1;
    @(negedge clk);
    check("idle_flush_no_req", 128'(mem_req_valid), 128'(0));
    flush_in = 1'b0; inst_deq = 1'b1;
    wait_drain("jal_fwd");

    // JAL -4 at 0: prediction wraps below zero and back.
    reset_low();
    jal_neg = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'hfffffffc); exp_req.push_back(32'h0);
    exp_ent.push_back({32'hffdff06f, 32'h0, 32'hfffffffc});
    exp_ent.push_back({32'h13, 32'hfffffffc, 32'h0});
    exp_ent.push_back({32'hffdff06f, 32'h0, 32'hfffffffc});
    rst_in = 1'b1; inst_deq = 1'b1;
    wait_drain("jal_back");
    jal_neg = 1'b0;

    // Fill to 16, then one dequeue and an enqueue+dequeue in the same cycle.
    reset_low();
    for (int a = 0; a < 72; a += 4) begin
      exp_req.push_back(32'(a));
      push_nop(32'(a));
    end
    base = req_seen;
    rst_in = 1'b1;
    repeat (40) @(negedge clk);
    check("full_no_req", 128'(mem_req_valid), 128'(0));
    check("full_inst_valid", 128'(inst_valid), 128'(1));
    check("full_req_count", 128'(req_seen - base), 128'(16));
    inst_deq = 1'b1;
    @(negedge clk);
    inst_deq = 1'b0;
    wait_req("refill");
    inst_deq = 1'b1;
    @(negedge clk);
    inst_deq = 1'b0;
    repeat (10) @(negedge clk);
    check("refull_no_req", 128'(mem_req_valid), 128'(0));
    check("refull_req_count", 128'(req_seen - base), 128'(18));
    check("refull_head_pc", 128'(inst_pc_out), 128'(32'h8));
    inst_deq = 1'b1;
    wait_drain("full");

    // Flush in WAIT, stale response three cycles later (memory driven by hand).
    auto_en = 1'b0;
    reset_low();
    exp_req.push_back(32'h0); exp_req.push_back(32'h200);
    push_nop(32'h200);
    rst_in = 1'b1; inst_deq = 1'b1;
    @(negedge clk);
    wait_req("pre_flush");
    flush_in = 1'b1; flush_pc_in = 32'h200;
    @(negedge clk);
    flush_in = 1'b0;
    check("drop_no_req_1", 128'(mem_req_valid), 128'(0));
    @(negedge clk);
    check("drop_no_req_2", 128'(mem_req_valid), 128'(0));
    @(negedge clk);
    man_v = 1'b1; man_d = 32'h0100006f;
    @(negedge clk);
    man_v = 1'b0;
    check("stale_discarded", 128'(inst_valid), 128'(0));
    check("stale_no_req", 128'(mem_req_valid), 128'(0));
    wait_req("after_drop");
    man_v = 1'b1; man_d = 32'h13;
    @(negedge clk);
    man_v = 1'b0;
    wait_drain("drop");

    // Flush with response in the same cycle, then a 5-cycle freeze mid-WAIT.
    auto_en = 1'b1;
    reset_low();
    exp_req.push_back(32'h0); exp_req.push_back(32'h300); exp_req.push_back(32'h304);
    push_nop(32'h300); push_nop(32'h304);
    rst_in = 1'b1;
    @(negedge clk);
    wait_req("pre_flush_resp");
    flush_in = 1'b1; flush_pc_in = 32'h300;
    @(negedge clk);
    flush_in = 1'b0;
    check("flush_resp_discarded", 128'(inst_valid), 128'(0));
    wait_req("fetch_300");
    @(negedge clk);
    wait_req("fetch_304");
    rdy_in = 1'b0; inst_deq = 1'b1; flush_in = 1'b1; flush_pc_in = 32'h400;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("frozen_req", 128'({mem_req_valid, mem_req_addr, inst_valid}),
            128'({1'b1, 32'h304, 1'b1}));
      check("frozen_head", 128'({inst_out, inst_pc_out, inst_pred_pc_out}),
            128'({32'h13, 32'h300, 32'h304}));
    end
    rdy_in = 1'b1; flush_in = 1'b0;
    wait_drain("freeze");

    // Asynchronous reset mid-WAIT, then a late response arriving in IDLE.
    inst_deq = 1'b0;
    repeat (4) @(negedge clk);
    wait_req("pre_async_rst");
    rst_in = 1'b0; auto_en = 1'b0;
    #1;
    check("arst_req_valid", 128'(mem_req_valid), 128'(0));
    check("arst_req_addr", 128'(mem_req_addr), 128'(0));
    check("arst_inst_valid", 128'(inst_valid), 128'(0));
    check("arst_head", 128'({inst_out, inst_pc_out, inst_pred_pc_out}), 128'(0));
    @(negedge clk);
    rst_in = 1'b1; man_v = 1'b1; man_d = 32'h13;
    @(negedge clk);
    man_v = 1'b0;
    check("idle_resp_ignored", 128'(inst_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
